controle_valvula_caixa: RTL and testbench

// - Sequential controller directly downstream of the tank level/error decoder (H/M/L sensor decoder).
// - Filters the decoder's outputs, then runs the inlet-valve state machine with minimum switching time.
// - Latches faults and drives a steady or blinking alarm.
// - Its outputs drive the physical valve relay and the alarm buzzer/LED.

---
 rtl/controle_valvula_caixa.sv | 238 +++++++++++++++++++++++
 tb/tb_controle_valvula_caixa.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_valvula_caixa.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : controle_valvula_caixa
// Description : Tank inlet-valve controller placed after the H/M/L level and
//               error decoder. Debounces the decoder outputs, runs the valve
//               state machine with a minimum switching interval, latches
//               faults and drives a steady or blinking alarm.
// Optional    : FILL_TIMEOUT_EN - adds a fill watchdog (ENCHENDO -> FALHA
//               when the level does not improve for FILL_TMO cycles).
// Ports       : clk, reset (sync, active high)
//               Ve, Al, ERRO, Nv_Critico/Baixo/Medio/Alto  decoder outputs
//               err_clr    operator fault-clear pulse
//               Valvula    valve drive (1 = open)
//               Alarme     alarm drive
//               Falha      fault latched
//               Falha_Tmo  latched fault came from fill timeout
//               Estado     0 OCIOSO, 1 ENCHENDO, 2 CHEIO, 3 FALHA
// Revision    : 1.0 - initial release
// ============================================================================
module controle_valvula_caixa #(
    parameter int FILT_CYC   = 16,
    parameter int MIN_SW     = 64,
    parameter int FILL_TMO   = 4096,
    parameter int BLINK_HALF = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ve,
    input  logic       Al,
    input  logic       ERRO,
    input  logic       Nv_Critico,
    input  logic       Nv_Baixo,
    input  logic       Nv_Medio,
    input  logic       Nv_Alto,
    input  logic       err_clr,
    output logic       Valvula,
    output logic       Alarme,
    output logic       Falha,
    output logic       Falha_Tmo,
    output logic [1:0] Estado
);

    localparam int c_STAB_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam int c_SW_W   = $clog2(MIN_SW + 1);
    localparam int c_BLK_W  = $clog2(2 * BLINK_HALF);

    localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(FILT_CYC - 1);
    localparam logic [c_SW_W-1:0]   c_SW_MAX   = c_SW_W'(MIN_SW);
    localparam logic [c_BLK_W-1:0]  c_BLK_HALF = c_BLK_W'(BLINK_HALF);
    localparam logic [c_BLK_W-1:0]  c_BLK_MAX  = c_BLK_W'(2 * BLINK_HALF - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ENCHENDO = 2'd1,
        CHEIO    = 2'd2,
        FALHA    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input filter
    // ------------------------------------------------------------------
    logic [6:0]          w_in;
    logic [6:0]          r_vec;
    logic [6:0]          r_q;
    logic [c_STAB_W-1:0] r_stab;

    assign w_in = {Ve, Al, ERRO, Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto};

    // r_stab counts how many consecutive cycles r_vec has kept its value
    // (minus one). Once it saturates the registered vector has been stable
    // for FILT_CYC cycles and is copied into the qualified vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec  <= '0;
            r_stab <= '0;
            r_q    <= '0;
        end else begin
            r_vec <= w_in;
            if (w_in != r_vec) begin
                r_stab <= '0;
            end else if (r_stab != c_STAB_MAX) begin
                r_stab <= r_stab + c_STAB_W'(1);
            end
            if (r_stab == c_STAB_MAX) begin
                r_q <= r_vec;
            end
        end
    end

    logic w_q_ve, w_q_al, w_q_erro, w_q_crit, w_q_baixo, w_q_medio, w_q_alto;
    assign {w_q_ve, w_q_al, w_q_erro, w_q_crit, w_q_baixo, w_q_medio, w_q_alto} = r_q;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valvula;
    logic               r_falha;
    logic [c_SW_W-1:0]  r_sw_cnt;
    logic               w_sw_ok;
    logic               w_valve_nxt;
    logic               w_timeout;

    assign w_sw_ok     = (r_sw_cnt == c_SW_MAX);
    assign w_valve_nxt = (w_state_nxt == ENCHENDO);

    always_comb begin
        w_state_nxt = r_state;
        if (w_q_erro) begin
            w_state_nxt = FALHA;
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (w_q_ve && w_sw_ok) w_state_nxt = ENCHENDO;
                end
                ENCHENDO: begin
                    // Full level closes the valve at once: overflow beats
                    // the anti-chatter interval.
                    if (w_q_alto)                  w_state_nxt = CHEIO;
                    else if (w_timeout)            w_state_nxt = FALHA;
                    else if (!w_q_ve && w_sw_ok)   w_state_nxt = OCIOSO;
                end
                CHEIO: begin
                    if (!w_q_alto && w_sw_ok) w_state_nxt = OCIOSO;
                end
                FALHA: begin
                    if (err_clr) w_state_nxt = OCIOSO;
                end
                default: w_state_nxt = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= OCIOSO;
            r_valvula <= 1'b0;
            r_falha   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_valvula <= w_valve_nxt;
            r_falha   <= (w_state_nxt == FALHA);
        end
    end

    // Cycles since the last valve transition, saturating; reset leaves it
    // saturated so the valve may open right away.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_cnt <= c_SW_MAX;
        end else if (w_valve_nxt != r_valvula) begin
            r_sw_cnt <= '0;
        end else if (!w_sw_ok) begin
            r_sw_cnt <= r_sw_cnt + c_SW_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Fill watchdog
    // ------------------------------------------------------------------
`ifdef FILL_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(FILL_TMO + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(FILL_TMO);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_prev_crit;
    logic               r_prev_baixo;
    logic               r_falha_tmo;
    logic               w_step_up;

    // Level improved since last cycle: Critico -> Baixo or Baixo -> Medio.
    assign w_step_up = (w_q_baixo & r_prev_crit) | (w_q_medio & r_prev_baixo);
    assign w_timeout = (r_tmo_cnt == c_TMO_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt    <= '0;
            r_prev_crit  <= 1'b0;
            r_prev_baixo <= 1'b0;
            r_falha_tmo  <= 1'b0;
        end else begin
            r_prev_crit  <= w_q_crit;
            r_prev_baixo <= w_q_baixo;
            if (r_state != ENCHENDO || w_step_up) begin
                r_tmo_cnt <= '0;
            end else if (!w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
            // Entering FALHA from ENCHENDO without q_ERRO can only be the
            // timeout path; staying in FALHA keeps the cause; q_ERRO always
            // overrides the cause to "sensor error".
            r_falha_tmo <= (w_state_nxt == FALHA) && !w_q_erro &&
                           (r_falha_tmo || (r_state == ENCHENDO));
        end
    end

    assign Falha_Tmo = r_falha_tmo;
`else
    logic w_unused_lvl;
    assign w_unused_lvl = ^{w_q_baixo, w_q_medio};
    assign w_timeout    = 1'b0;
    assign Falha_Tmo    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Alarm
    // ------------------------------------------------------------------
    logic [c_BLK_W-1:0] r_blink;
    logic               r_alarme;
    logic               w_blink_on;

    // Critical level gives a steady alarm and masks the blink, so the blink
    // phase restarts at "on" whenever blinking resumes.
    assign w_blink_on = !w_q_crit && ((r_state == FALHA) || w_q_al);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink  <= '0;
            r_alarme <= 1'b0;
        end else begin
            if (!w_blink_on || r_blink == c_BLK_MAX) begin
                r_blink <= '0;
            end else begin
                r_blink <= r_blink + c_BLK_W'(1);
            end
            r_alarme <= w_q_crit || (w_blink_on && (r_blink < c_BLK_HALF));
        end
    end

    assign Valvula = r_valvula;
    assign Falha   = r_falha;
    assign Alarme  = r_alarme;
    assign Estado  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_controle_valvula_caixa.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_controle_valvula_caixa
// Description : Self-checking bench for controle_valvula_caixa. Directed
//               scenarios followed by randomized input segments, every cycle
//               compared with a behavioural model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_valvula_caixa;

    localparam int FILT_CYC   = 4;
    localparam int MIN_SW     = 8;
    localparam int FILL_TMO   = 100;
    localparam int BLINK_HALF = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Ve = 1'b0, Al = 1'b0, ERRO = 1'b0, err_clr = 1'b0;
    logic       Nv_Critico = 1'b0, Nv_Baixo = 1'b0, Nv_Medio = 1'b0, Nv_Alto = 1'b0;
    logic       Valvula, Alarme, Falha, Falha_Tmo;
    logic [1:0] Estado;

    always #5 clk = ~clk;

    controle_valvula_caixa #(
        .FILT_CYC  (FILT_CYC),
        .MIN_SW    (MIN_SW),
        .FILL_TMO  (FILL_TMO),
        .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Ve        (Ve),
        .Al        (Al),
        .ERRO      (ERRO),
        .Nv_Critico(Nv_Critico),
        .Nv_Baixo  (Nv_Baixo),
        .Nv_Medio  (Nv_Medio),
        .Nv_Alto   (Nv_Alto),
        .err_clr   (err_clr),
        .Valvula   (Valvula),
        .Alarme    (Alarme),
        .Falha     (Falha),
        .Falha_Tmo (Falha_Tmo),
        .Estado    (Estado)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // ---------------- behavioural model ----------------
    bit [6:0] hist[$];          // raw samples since reset, newest last
    bit [6:0] m_q, m_q_prev;    // accepted (debounced) vector
    int       m_state;
    bit       m_valve, m_falha, m_tmo, m_alarm;
    int       m_since;          // cycles since the valve last changed
    int       m_brun;           // consecutive cycles the blink condition held
    int       m_fill;           // cycles in ENCHENDO without level progress

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit [6:0] smp;
        bit [6:0] new_q;
        bit       agree, ok, tmo_hit, step, crit, blink;
        int       ns;
        bit       ntmo, nvalve;
        smp = {Ve, Al, ERRO, Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto};
        if (reset) begin
            hist.delete();
            hist.push_back(7'd0);
            m_q = 0; m_q_prev = 0; m_state = 0;
            m_valve = 0; m_falha = 0; m_tmo = 0; m_alarm = 0;
            m_since = MIN_SW; m_brun = 0; m_fill = 0;
            return;
        end
        // Debounce: accept a vector once FILT_CYC consecutive samples agree.
        new_q = m_q;
        agree = (hist.size() >= FILT_CYC);
        for (int i = 1; i < hist.size(); i++)
            if (hist[i] != hist[0]) agree = 0;
        if (agree) new_q = hist[0];

        ok = (m_since >= MIN_SW);
`ifdef FILL_TIMEOUT_EN
        tmo_hit = (m_fill >= FILL_TMO);
`else
        tmo_hit = 0;
`endif
        ns = m_state;
        ntmo = m_tmo;
        if (m_q[4]) begin
            ns = 3; ntmo = 0;
        end else begin
            case (m_state)
                0: if (m_q[6] && ok) ns = 1;
                1: begin
                    if (m_q[0]) ns = 2;
                    else if (tmo_hit) begin ns = 3; ntmo = 1; end
                    else if (!m_q[6] && ok) ns = 0;
                end
                2: if (!m_q[0] && ok) ns = 0;
                default: if (err_clr) begin ns = 0; ntmo = 0; end
            endcase
        end

        step = (m_q[2] && m_q_prev[3]) || (m_q[1] && m_q_prev[2]);
        if (m_state != 1 || step) m_fill = 0;
        else m_fill = m_fill + 1;

        crit  = m_q[3];
        blink = !crit && (m_state == 3 || m_q[5]);
        m_alarm = crit || (blink && ((m_brun % (2 * BLINK_HALF)) < BLINK_HALF));
        m_brun  = blink ? m_brun + 1 : 0;

        nvalve  = (ns == 1);
        m_since = (nvalve != m_valve) ? 0 : m_since + 1;
        m_valve = nvalve;
        m_falha = (ns == 3);
        m_tmo   = ntmo;
        m_state = ns;

        hist.push_back(smp);
        if (hist.size() > FILT_CYC) void'(hist.pop_front());
        m_q_prev = m_q;
        m_q = new_q;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
        chk("Estado",    Estado,    m_state);
        chk("Valvula",   Valvula,   m_valve);
        chk("Falha",     Falha,     m_falha);
        chk("Falha_Tmo", Falha_Tmo, m_tmo);
        chk("Alarme",    Alarme,    m_alarm);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Level index: 0 Critico, 1 Baixo, 2 Medio, 3 Alto, other = none.
    task automatic set_lvl(input int l);
        Nv_Critico = (l == 0);
        Nv_Baixo   = (l == 1);
        Nv_Medio   = (l == 2);
        Nv_Alto    = (l == 3);
    endtask

    task automatic wait_open(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (Valvula === 1'b1) break;
            tick();
        end
        chk(tag, Valvula, 1);
    endtask

    initial begin
        int seg;
        // ---- reset ----
        ticks(2);
        chk("rst_estado",  Estado, 0);
        chk("rst_valvula", Valvula, 0);
        chk("rst_alarme",  Alarme, 0);
        reset = 0;
        ticks(3);

        // ---- T1 fill start: valve opens exactly FILT_CYC+2 edges later ----
        Ve = 1; set_lvl(0);
        ticks(5);
        chk("t1_estado_edge5", Estado, 0);
        tick();
        chk("t1_estado_edge6",  Estado, 1);
        chk("t1_valvula_edge6", Valvula, 1);
        chk("t1_alarme_crit",   Alarme, 1);

        // ---- T2 glitch reject, then real error ----
        ticks(10);
        ERRO = 1; ticks(3); ERRO = 0;
        ticks(10);
        chk("t2_glitch_estado", Estado, 1);
        chk("t2_glitch_falha",  Falha, 0);
        ERRO = 1; ticks(5); ERRO = 0;
        ticks(3);
        chk("t2_err_estado",  Estado, 3);
        chk("t2_err_valvula", Valvula, 0);
        ticks(8);
        err_clr = 1; tick(); err_clr = 0;
        chk("t2_clr_estado", Estado, 0);

        // ---- T3 overflow ignores anti-chatter ----
        wait_open("t3_open");
        ticks(2);
        set_lvl(3);
        ticks(6);
        chk("t3_cheio", Estado, 2);
        chk("t3_closed", Valvula, 0);
        Ve = 0; set_lvl(2);
        ticks(14);
        chk("t3_ocioso", Estado, 0);

        // ---- T4 anti-chatter on close ----
        Ve = 1; set_lvl(1);
        wait_open("t4_open");
        tick();
        Ve = 0;
        ticks(7);
        chk("t4_min_on", Valvula, 1);
        ticks(6);
        chk("t4_closed", Valvula, 0);

        // ---- T5 fill timeout ----
        Ve = 1; set_lvl(1);
        ticks(130);
`ifdef FILL_TIMEOUT_EN
        chk("t5_estado", Estado, 3);
        chk("t5_tmo",    Falha_Tmo, 1);
        ticks(20);
        Ve = 0; ticks(6);
        err_clr = 1; tick(); err_clr = 0;
        chk("t5_clr_estado", Estado, 0);
        chk("t5_clr_tmo",    Falha_Tmo, 0);
`else
        chk("t5_estado",  Estado, 1);
        chk("t5_valvula", Valvula, 1);
        Ve = 0; ticks(20);
`endif

        // ---- T6 reset mid-fill ----
        Ve = 1; set_lvl(2);
        wait_open("t6_open");
        ticks(3);
        reset = 1; tick(); reset = 0;
        chk("t6_valvula", Valvula, 0);
        chk("t6_estado",  Estado, 0);
        ticks(5);
        chk("t6_pre", Estado, 0);
        tick();
        chk("t6_reopen", Valvula, 1);

        // ---- randomized segments ----
        for (int s = 0; s < 400; s++) begin
            Ve   = $urandom_range(0, 1);
            Al   = ($urandom_range(0, 3) == 0);
            ERRO = ($urandom_range(0, 9) == 0);
            set_lvl($urandom_range(0, 4));
            seg = $urandom_range(1, 12);
            for (int c = 0; c < seg; c++) begin
                err_clr = ($urandom_range(0, 5) == 0);
                reset   = ($urandom_range(0, 199) == 0);
                tick();
            end
            err_clr = 0; reset = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
